// File: rtl/jacobi_pivot_engine.sv
// Symmetric N x N matrix store with pivot selection for a Jacobi eigen-solver:
// classical (largest |M_ij|) or cyclic sweep, plus an element write-back port.
module jacobi_pivot_engine #(
    parameter int             N     = 32,
    parameter int             W     = 32,
    parameter int             IDX_W = 5,
    parameter logic [W-1:0]   EPS   = 32'h3727C5AC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              load_req,
    input  logic              row_valid,
    output logic              row_ready,
    input  logic [N*W-1:0]    row_data,
    input  logic              start,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_i,
    input  logic [IDX_W-1:0]  wr_j,
    input  logic [W-1:0]      wr_data,
    output logic              busy,
    output logic              loaded,
    output logic              piv_valid,
    input  logic              piv_ready,
    output logic [IDX_W-1:0]  piv_i,
    output logic [IDX_W-1:0]  piv_j,
    output logic [W-1:0]      m_ii,
    output logic [W-1:0]      m_jj,
    output logic [W-1:0]      m_ij,
    output logic              converged
);

    typedef enum logic [1:0] {S_LOAD, S_IDLE, S_SCAN, S_OUT} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] i;
        logic [IDX_W-1:0] j;
    } pair_t;

    // Element k of a row sits at packed index N-1-k, so a row beat is stored as-is.
    typedef logic [N-1:0][W-1:0] row_t;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(N - 2);
    localparam logic [W-2:0]     EPS_MAG    = EPS[W-2:0];
    localparam pair_t            FIRST_PAIR = '{i: '0, j: IDX_W'(1)};

    function automatic logic [IDX_W-1:0] col(input logic [IDX_W-1:0] j);
        return LAST_IDX - j;
    endfunction

    // Row-major walk of the strict upper triangle, wrapping after (N-2, N-1).
    function automatic pair_t next_pair(input pair_t p);
        pair_t n;
        if (p.j != LAST_IDX) begin
            n.i = p.i;
            n.j = p.j + IDX_W'(1);
        end else if (p.i == PENULT_IDX) begin
            n = FIRST_PAIR;
        end else begin
            n.i = p.i + IDX_W'(1);
            n.j = p.i + IDX_W'(2);
        end
        return n;
    endfunction

    function automatic logic last_pair(input pair_t p);
        return (p.i == PENULT_IDX) && (p.j == LAST_IDX);
    endfunction

    state_t           state_q, state_d;
    row_t             mem_q [N];
    logic [IDX_W-1:0] row_cnt_q;
    logic             loaded_q;
    logic             mode_q;
    pair_t            cur_q;
    pair_t            scan_q;
    pair_t            best_q;
    logic [W-2:0]     best_mag_q;
    logic [IDX_W-1:0] piv_i_q, piv_j_q;
    logic [W-1:0]     m_ii_q, m_jj_q, m_ij_q;
    logic             conv_q;

    logic             wr_in_range;
    logic             load_beat;
    logic             idle_write;
    logic             go;
    logic             cyc_go;
    logic             scan_done;
    logic             handshake;
    logic             latch_pivot;
    logic [W-2:0]     cand_mag;
    logic             take;
    pair_t            best_nx;
    logic [W-2:0]     best_mag_nx;
    pair_t            sel;
    logic [W-1:0]     sel_ii, sel_jj, sel_ij;

    generate
        if (N == (1 << IDX_W)) begin : g_pow2
            assign wr_in_range = 1'b1;
        end else begin : g_npow2
            localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N);
            assign wr_in_range = ({1'b0, wr_i} < N_EXT) && ({1'b0, wr_j} < N_EXT);
        end
    endgenerate

    assign load_beat   = (state_q == S_LOAD) && row_valid;
    assign idle_write  = (state_q == S_IDLE) && wr_en && wr_in_range;
    assign go          = (state_q == S_IDLE) && !load_req && start && loaded_q;
    assign cyc_go      = go && mode;
    assign scan_done   = (state_q == S_SCAN) && last_pair(scan_q);
    assign handshake   = (state_q == S_OUT) && piv_ready;
    assign latch_pivot = scan_done || cyc_go;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: if (load_beat && (row_cnt_q == LAST_IDX)) state_d = S_IDLE;
            S_IDLE: begin
                if (load_req) begin
                    state_d = S_LOAD;
                end else if (start && loaded_q) begin
                    state_d = mode ? S_OUT : S_SCAN;
                end
            end
            S_SCAN: if (last_pair(scan_q)) state_d = S_OUT;
            S_OUT:  if (piv_ready) state_d = S_IDLE;
            default: state_d = S_LOAD;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        row_ready = 1'b0;
        busy      = 1'b0;
        piv_valid = 1'b0;
        case (state_q)
            S_LOAD: begin
                row_ready = 1'b1;
                busy      = 1'b1;
            end
            S_SCAN:  busy      = 1'b1;
            S_OUT:   piv_valid = 1'b1;
            default: ;
        endcase
    end

    // Classical search: strictly-greater keeps the earliest pair on a tie.
    assign cand_mag    = mem_q[scan_q.i][col(scan_q.j)][W-2:0];
    assign take        = cand_mag > best_mag_q;
    assign best_nx     = take ? scan_q : best_q;
    assign best_mag_nx = take ? cand_mag : best_mag_q;
    assign sel         = (state_q == S_SCAN) ? best_nx : cur_q;

    // A write in the same cycle as a cyclic start must be visible in the latched pivot.
    always_comb begin
        sel_ii = mem_q[sel.i][col(sel.i)];
        sel_jj = mem_q[sel.j][col(sel.j)];
        sel_ij = mem_q[sel.i][col(sel.j)];
        if (idle_write) begin
            if ((wr_i == sel.i) && (wr_j == sel.i)) sel_ii = wr_data;
            if ((wr_i == sel.j) && (wr_j == sel.j)) sel_jj = wr_data;
            if (((wr_i == sel.i) && (wr_j == sel.j)) || ((wr_i == sel.j) && (wr_j == sel.i))) begin
                sel_ij = wr_data;
            end
        end
    end

    // NOTE: the matrix has no reset; every entry is written by a full load before it is read.
    always_ff @(posedge clk) begin
        if (load_beat) begin
            mem_q[row_cnt_q] <= row_data;
        end else if (idle_write) begin
            mem_q[wr_i][col(wr_j)] <= wr_data;
            mem_q[wr_j][col(wr_i)] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt_q  <= '0;
            loaded_q   <= 1'b0;
            mode_q     <= 1'b0;
            cur_q      <= FIRST_PAIR;
            scan_q     <= FIRST_PAIR;
            best_q     <= FIRST_PAIR;
            best_mag_q <= '0;
            piv_i_q    <= '0;
            piv_j_q    <= '0;
            m_ii_q     <= '0;
            m_jj_q     <= '0;
            m_ij_q     <= '0;
            conv_q     <= 1'b0;
        end else begin
            if (load_beat) begin
                if (row_cnt_q == LAST_IDX) begin
                    row_cnt_q <= '0;
                    loaded_q  <= 1'b1;
                end else begin
                    row_cnt_q <= row_cnt_q + IDX_W'(1);
                end
            end

            if ((state_q == S_IDLE) && load_req) begin
                row_cnt_q <= '0;
                loaded_q  <= 1'b0;
            end

            if (go) begin
                mode_q     <= mode;
                scan_q     <= FIRST_PAIR;
                best_q     <= FIRST_PAIR;
                best_mag_q <= '0;
            end

            if (state_q == S_SCAN) begin
                scan_q     <= next_pair(scan_q);
                best_q     <= best_nx;
                best_mag_q <= best_mag_nx;
            end

            if (latch_pivot) begin
                piv_i_q <= sel.i;
                piv_j_q <= sel.j;
                m_ii_q  <= sel_ii;
                m_jj_q  <= sel_jj;
                m_ij_q  <= sel_ij;
                conv_q  <= sel_ij[W-2:0] <= EPS_MAG;
            end

            if (handshake && mode_q) begin
                cur_q <= next_pair(cur_q);
            end
        end
    end

    assign loaded    = loaded_q;
    assign piv_i     = piv_i_q;
    assign piv_j     = piv_j_q;
    assign m_ii      = m_ii_q;
    assign m_jj      = m_jj_q;
    assign m_ij      = m_ij_q;
    assign converged = conv_q;

endmodule

// File: tb/tb_jacobi_pivot_engine.sv
// Self-checking bench for jacobi_pivot_engine (N=4): directed scenarios plus
// randomized matrices checked against a plain-arithmetic reference model.
module tb_jacobi_pivot_engine;

    localparam int          N     = 4;
    localparam int          W     = 32;
    localparam int          IDX_W = 2;
    localparam int          NP    = N * (N - 1) / 2;
    localparam logic [31:0] EPS_T = 32'h3727C5AC;

    typedef logic [2*IDX_W+3*W:0] piv_vec_t;

    logic             clk = 1'b0;
    logic             reset, mode, load_req, row_valid, start, wr_en, piv_ready;
    logic [N*W-1:0]   row_data;
    logic [IDX_W-1:0] wr_i, wr_j, piv_i, piv_j;
    logic [W-1:0]     wr_data, m_ii, m_jj, m_ij;
    logic             row_ready, busy, loaded, piv_valid, converged;
    piv_vec_t         obs_vec;

    logic [31:0] ref_m [N][N];
    int          pi_tab [NP];
    int          pj_tab [NP];
    int          cyc_k;
    int          checks = 0;
    int          errors = 0;

    jacobi_pivot_engine #(.N(N), .W(W), .IDX_W(IDX_W), .EPS(EPS_T)) dut (
        .clk(clk), .reset(reset), .mode(mode), .load_req(load_req),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .start(start), .wr_en(wr_en), .wr_i(wr_i), .wr_j(wr_j), .wr_data(wr_data),
        .busy(busy), .loaded(loaded), .piv_valid(piv_valid), .piv_ready(piv_ready),
        .piv_i(piv_i), .piv_j(piv_j), .m_ii(m_ii), .m_jj(m_jj), .m_ij(m_ij),
        .converged(converged)
    );

    always #5 clk = ~clk;

    assign obs_vec = {piv_i, piv_j, m_ii, m_jj, m_ij, converged};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [30:0] mag(input logic [31:0] x);
        return x[30:0];
    endfunction

    task automatic ref_write(input int i, input int j, input logic [31:0] d);
        ref_m[i][j] = d;
        ref_m[j][i] = d;
    endtask

    task automatic ref_classical(output int bi, output int bj);
        bit found = 0;
        bi = 0;
        bj = 1;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                if (!found || mag(ref_m[i][j]) > mag(ref_m[bi][bj])) begin
                    bi = i;
                    bj = j;
                    found = 1;
                end
            end
        end
    endtask

    function automatic piv_vec_t exp_pivot(input int bi, input int bj);
        logic [IDX_W-1:0] ii, jj;
        ii = IDX_W'(bi);
        jj = IDX_W'(bj);
        return {ii, jj, ref_m[bi][bi], ref_m[bj][bj], ref_m[bi][bj],
                mag(ref_m[bi][bj]) <= EPS_T[30:0]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mode = 0; load_req = 0; row_valid = 0; start = 0; wr_en = 0; piv_ready = 0;
        row_data = '0; wr_i = '0; wr_j = '0; wr_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        cyc_k = 0;
    endtask

    task automatic load_all(input bit noise);
        if (row_ready !== 1'b1) begin
            load_req = 1;
            tick();
            load_req = 0;
        end
        for (int r = 0; r < N; r++) begin
            row_valid = 1;
            for (int k = 0; k < N; k++) row_data[(N-1-k)*W +: W] = ref_m[r][k];
            if (noise) begin
                start   = 1'($urandom);
                mode    = 1'($urandom);
                wr_en   = 1'($urandom);
                wr_i    = IDX_W'($urandom);
                wr_j    = IDX_W'($urandom);
                wr_data = $urandom;
            end
            tick();
        end
        row_valid = 0; start = 0; wr_en = 0;
    endtask

    task automatic write_elem(input int i, input int j, input logic [31:0] d);
        wr_en = 1; wr_i = IDX_W'(i); wr_j = IDX_W'(j); wr_data = d;
        tick();
        wr_en = 0;
        ref_write(i, j, d);
    endtask

    task automatic wait_valid(input int first, output int edges, output bit timeout);
        edges = first;
        while (piv_valid !== 1'b1 && edges < 200) begin
            tick();
            edges++;
        end
        timeout = (piv_valid !== 1'b1);
    endtask

    task automatic run_pivot(input bit m, output int edges, output bit timeout);
        mode = m;
        start = 1;
        tick();
        start = 0;
        wait_valid(1, edges, timeout);
    endtask

    task automatic accept(input bit was_cyclic);
        piv_ready = 1;
        tick();
        piv_ready = 0;
        if (was_cyclic) cyc_k = (cyc_k + 1) % NP;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({row_ready, busy, loaded, piv_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_flags: got %b want 1100", {row_ready, busy, loaded, piv_valid});
        end
        checks++;
        if (obs_vec !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", obs_vec);
        end
    endtask

    task automatic test_classical();
        logic [31:0] plan [N*N] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                    32'h40000000, 32'h40A00000, 32'hC1100000, 32'h40C00000,
                                    32'h40400000, 32'hC1100000, 32'h40E00000, 32'h41000000,
                                    32'h40800000, 32'h40C00000, 32'h41000000, 32'h41100000};
        int edges, bi, bj;
        bit to;
        piv_vec_t exp;
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) ref_m[r][k] = plan[r*N+k];
        load_all(0);
        checks++;
        if ({row_ready, busy, loaded} !== 3'b001) begin
            errors++;
            $display("FAIL load_done: got %b want 001", {row_ready, busy, loaded});
        end
        run_pivot(0, edges, to);
        checks++;
        if (to || edges != 7) begin
            errors++;
            $display("FAIL classical_latency: got %0d edges (timeout %0d) want 7", edges, to);
        end
        ref_classical(bi, bj);
        exp = exp_pivot(bi, bj);
        checks++;
        if (obs_vec !== exp) begin
            errors++;
            $display("FAIL classical_model: got %h want %h", obs_vec, exp);
        end
        checks++;
        if (obs_vec !== {2'd1, 2'd2, 32'h40A00000, 32'h40E00000, 32'hC1100000, 1'b0}) begin
            errors++;
            $display("FAIL classical_plan: got %h want pivot (1,2) m_ij C1100000", obs_vec);
        end
        accept(0);
        checks++;
        if (piv_valid !== 1'b0 || obs_vec !== exp) begin
            errors++;
            $display("FAIL after_handshake: got valid %b vec %h want 0 / %h", piv_valid, obs_vec, exp);
        end
    endtask

    task automatic test_cyclic();
        int edges;
        bit to;
        piv_vec_t exp;
        for (int n = 0; n < 7; n++) begin
            exp = exp_pivot(pi_tab[cyc_k], pj_tab[cyc_k]);
            run_pivot(1, edges, to);
            checks++;
            if (to || edges != 1) begin
                errors++;
                $display("FAIL cyclic_latency[%0d]: got %0d edges want 1", n, edges);
            end
            checks++;
            if (obs_vec !== exp) begin
                errors++;
                $display("FAIL cyclic_pivot[%0d]: got %h want %h", n, obs_vec, exp);
            end
            accept(1);
        end
    endtask

    task automatic test_tie();
        int edges, bi, bj;
        bit to;
        do_reset();
        load_all(0);
        write_elem(0, 1, 32'h41200000);
        write_elem(3, 2, 32'h41200000);
        run_pivot(0, edges, to);
        ref_classical(bi, bj);
        checks++;
        if (to || piv_i !== 2'd0 || piv_j !== 2'd1 || obs_vec !== exp_pivot(bi, bj)) begin
            errors++;
            $display("FAIL tie_first: got (%0d,%0d) %h want (0,1) %h", piv_i, piv_j, obs_vec, exp_pivot(bi, bj));
        end
        accept(0);
        // write-back and start in the same cycle: the search must see the new value
        wr_en = 1; wr_i = 2'd1; wr_j = 2'd0; wr_data = '0; mode = 0; start = 1;
        tick();
        wr_en = 0; start = 0;
        ref_write(1, 0, '0);
        wait_valid(1, edges, to);
        ref_classical(bi, bj);
        checks++;
        if (to || piv_i !== 2'd2 || piv_j !== 2'd3 || obs_vec !== exp_pivot(bi, bj)) begin
            errors++;
            $display("FAIL tie_after_write: got (%0d,%0d) %h want (2,3) %h", piv_i, piv_j, obs_vec, exp_pivot(bi, bj));
        end
        accept(0);
        run_pivot(1, edges, to);
        checks++;
        if (to || m_ij !== 32'h0 || obs_vec !== exp_pivot(0, 1)) begin
            errors++;
            $display("FAIL mirror_readback: got m_ij %h want 00000000", m_ij);
        end
        accept(1);
    endtask

    task automatic test_backpressure();
        int edges, bi, bj, bad;
        bit to;
        piv_vec_t exp;
        run_pivot(0, edges, to);
        ref_classical(bi, bj);
        exp = exp_pivot(bi, bj);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            start = 1; mode = 1'($urandom); load_req = (c == 2);
            wr_en = 1; wr_i = IDX_W'(bi); wr_j = IDX_W'(bj); wr_data = 32'h7F000000;
            tick();
            if (piv_valid !== 1'b1 || obs_vec !== exp) bad++;
        end
        start = 0; load_req = 0; wr_en = 0;
        checks++;
        if (to || bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: got %0d unstable cycles, vec %h want 0 / %h", bad, obs_vec, exp);
        end
        accept(0);
        checks++;
        if (row_ready !== 1'b0 || loaded !== 1'b1) begin
            errors++;
            $display("FAIL out_ignores_load: got ready %b loaded %b want 0 1", row_ready, loaded);
        end
        run_pivot(0, edges, to);
        checks++;
        if (to || obs_vec !== exp) begin
            errors++;
            $display("FAIL backpressure_next: got %h want %h", obs_vec, exp);
        end
        accept(0);
        run_pivot(1, edges, to);
        checks++;
        if (to || obs_vec !== exp_pivot(pi_tab[cyc_k], pj_tab[cyc_k])) begin
            errors++;
            $display("FAIL cursor_hold: got %h want %h", obs_vec, exp_pivot(pi_tab[cyc_k], pj_tab[cyc_k]));
        end
        accept(1);
    endtask

    task automatic test_convergence();
        logic [31:0] vals [4] = '{32'h358637BD, 32'hB7A7C5AC, 32'hB727C5AC, 32'h3727C5AD};
        int exp_i [4] = '{0, 0, 1, 1};
        int exp_j [4] = '{1, 3, 2, 2};
        bit exp_c [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int edges, bi, bj;
        bit to;
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++) write_elem(i, j, vals[0]);
        for (int s = 0; s < 4; s++) begin
            if (s == 1) write_elem(0, 3, vals[1]);
            if (s == 2) begin
                write_elem(3, 0, vals[0]);
                write_elem(1, 2, vals[2]);
            end
            if (s == 3) write_elem(2, 1, vals[3]);
            run_pivot(0, edges, to);
            ref_classical(bi, bj);
            checks++;
            if (to || obs_vec !== exp_pivot(bi, bj) || piv_i !== IDX_W'(exp_i[s]) ||
                piv_j !== IDX_W'(exp_j[s]) || converged !== exp_c[s]) begin
                errors++;
                $display("FAIL convergence[%0d]: got (%0d,%0d) conv %b vec %h want (%0d,%0d) conv %b vec %h",
                         s, piv_i, piv_j, converged, obs_vec, exp_i[s], exp_j[s], exp_c[s], exp_pivot(bi, bj));
            end
            accept(0);
        end
    endtask

    task automatic test_reset_mid_scan();
        int edges, bi, bj;
        bit to;
        mode = 0; start = 1;
        tick();
        start = 0;
        tick();
        tick();
        reset = 1;
        tick();
        reset = 0;
        cyc_k = 0;
        checks++;
        if ({row_ready, busy, loaded, piv_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_mid_scan: got %b want 1100", {row_ready, busy, loaded, piv_valid});
        end
        for (int c = 0; c < 8; c++) tick();
        checks++;
        if (piv_valid !== 1'b0 || row_ready !== 1'b1) begin
            errors++;
            $display("FAIL scan_discarded: got valid %b ready %b want 0 1", piv_valid, row_ready);
        end
        load_all(1);
        row_valid = 1;
        row_data = {$urandom, $urandom, $urandom, $urandom};
        mode = 0; start = 1;
        tick();
        start = 0;
        tick();
        checks++;
        if (row_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL scan_not_ready: got ready %b busy %b want 0 1", row_ready, busy);
        end
        wait_valid(2, edges, to);
        row_valid = 0;
        ref_classical(bi, bj);
        checks++;
        if (to || edges != 7 || obs_vec !== exp_pivot(bi, bj)) begin
            errors++;
            $display("FAIL reload_pivot: got %h after %0d edges want %h after 7", obs_vec, edges, exp_pivot(bi, bj));
        end
        accept(0);
    endtask

    task automatic test_random();
        int edges, bi, bj, nw;
        bit to;
        logic [31:0] v;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = i; j < N; j++) begin
                    v[31]   = 1'($urandom);
                    v[30:0] = (it % 2 == 0) ? 31'($urandom_range(0, 32'h38000000)) : 31'($urandom);
                    ref_write(i, j, v);
                end
            end
            load_req = 1; start = 1; mode = 1'($urandom);
            tick();
            load_req = 0; start = 0;
            checks++;
            if ({row_ready, loaded, piv_valid} !== 3'b100) begin
                errors++;
                $display("FAIL load_req_priority[%0d]: got %b want 100", it, {row_ready, loaded, piv_valid});
            end
            load_all(it % 2 == 1);
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                write_elem($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom);
            run_pivot(0, edges, to);
            ref_classical(bi, bj);
            checks++;
            if (to || edges != 7 || obs_vec !== exp_pivot(bi, bj)) begin
                errors++;
                $display("FAIL random_classical[%0d]: got %h after %0d edges want %h", it, obs_vec, edges, exp_pivot(bi, bj));
            end
            accept(0);
            run_pivot(1, edges, to);
            checks++;
            if (to || edges != 1 || obs_vec !== exp_pivot(pi_tab[cyc_k], pj_tab[cyc_k])) begin
                errors++;
                $display("FAIL random_cyclic[%0d]: got %h want %h", it, obs_vec, exp_pivot(pi_tab[cyc_k], pj_tab[cyc_k]));
            end
            accept(1);
        end
    endtask

    initial begin
        int k = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                pi_tab[k] = i;
                pj_tab[k] = j;
                k++;
            end
        end
        test_reset();
        test_classical();
        test_cyclic();
        test_tie();
        test_backpressure();
        test_convergence();
        test_reset_mid_scan();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jacobi_pivot_engine.md
Name: jacobi_pivot_engine

Overview:
- Parametrised matrix store and pivot selector for the Jacobi eigen-solver datapath.
- Loads an N x N symmetric matrix of W-bit sign-magnitude floats (IEEE-754 single at default), one row per beat.
- On request, selects the next rotation pivot (i, j), either by classical search (largest |M_ij|) or by cyclic sweep order, and presents i, j, M_ii, M_jj, M_ij with a convergence flag.
- Provides an element write port so the rotation unit can write updated values back between pivots.

Parameters:
- N, 32, matrix dimension; N >= 2.
- W, 32, element width; bit W-1 is sign, bits W-2:0 form the magnitude.
- IDX_W, 5, index width; must equal clog2(N).
- EPS, 32'h3727C5AC, W-bit convergence threshold (1e-5); only its magnitude bits are used.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- mode  in  1  0 = classical (max search), 1 = cyclic; sampled with start.
- load_req  in  1  pulse: re-enter LOAD.
- row_valid  in  1  row beat valid.
- row_ready  out  1  high only in LOAD.
- row_data  in  N*W  one row; element k at bits [(N-k)*W-1 -: W] (element 0 at MSBs).
- start  in  1  pulse: request a pivot.
- wr_en  in  1  element write.
- wr_i, wr_j  in  IDX_W each  write indices.
- wr_data  in  W  write value.
- busy  out  1  high in LOAD or SCAN.
- loaded  out  1  full matrix present.
- piv_valid  out  1  pivot result valid.
- piv_ready  in  1  consumer accepts the result.
- piv_i, piv_j  out  IDX_W each  pivot indices, piv_i < piv_j.
- m_ii, m_jj, m_ij  out  W each  pivot elements.
- converged  out  1  |m_ij| <= |EPS|.

Behaviour:
- States: LOAD, IDLE, SCAN, OUT.
- Reset:
  - State = LOAD, row counter = 0, loaded = 0, cyclic cursor = (0,1).
  - All pivot outputs and piv_valid = 0.
  - Matrix storage is not cleared.
- LOAD:
  - row_ready = 1. Each beat with row_valid & row_ready writes row[counter] and increments the counter.
  - The beat on row N-1 sets loaded = 1 and moves to IDLE.
  - start and wr_en are ignored in LOAD.
- IDLE:
  - Priority: load_req > start. load_req clears loaded and resets the row counter to 0.
  - start with loaded = 0 is ignored.
  - wr_en writes M[wr_i][wr_j] and M[wr_j][wr_i] at the same edge. wr_i = wr_j writes the diagonal once.
  - wr_en is honoured only in IDLE; in every other state it is silently dropped.
  - wr_en and start in the same cycle: the write commits at that edge, and the search sees the new value.
- Classical search:
  - The edge sampling start enters SCAN. Upper-triangle pairs are visited row-major: (0,1), (0,2) … (N-2,N-1), one compare per cycle, N(N-1)/2 cycles in total.
  - Magnitude compare is an unsigned compare on bits W-2:0; sign is ignored.
  - Strictly greater replaces the current best, so on a tie the first pair in scan order wins.
  - The last compare edge moves to OUT.
  - piv_valid rises N(N-1)/2+1 edges after the start edge (7 edges for N=4).
- Cyclic mode:
  - The start edge latches the cursor pair directly and goes IDLE -> OUT, so piv_valid is high after 1 edge.
  - The cursor advances on the OUT handshake: (i,j+1); if j = N-1, then (i+1,i+2); after (N-2,N-1) it wraps to (0,1).
  - Classical mode never moves the cursor.
- OUT:
  - piv_valid = 1. piv_i, piv_j, m_ii, m_jj, m_ij and converged stay stable until piv_valid & piv_ready, which returns to IDLE.
  - Outputs hold their last values after the handshake; piv_valid drops.
  - start and load_req are ignored in OUT.
- converged is registered with the pivot, using the same magnitude rule: |m_ij| <= |EPS|.
- Reset asserted in any state, including mid-SCAN or mid-OUT, takes effect at the next edge; the partial search is discarded.
- Indices beyond N-1 are only possible when N is not a power of two. wr_i or wr_j >= N drops the write.

Test Plan:
- N=4: load rows {1,2,3,4},{2,5,-9,6},{3,-9,7,8},{4,6,8,9} (float), classical start -> piv_valid after 7 edges; i=1, j=2, m_ij = -9.0 (0xC1100000), m_ii = 5.0, m_jj = 7.0, converged = 0.
- Tie: make M01 = M23 = 10.0 as the largest, classical -> (0,1) reported. Then write wr_i=0, wr_j=1, wr_data=0 and start in the same cycle -> (2,3) reported, and M10 reads back 0.
- Cyclic: 7 consecutive starts with piv_ready=1 -> (0,1),(0,2),(0,3),(1,2),(1,3),(2,3),(0,1); each piv_valid arrives 1 edge after start.
- Backpressure: hold piv_ready=0 for 5 cycles with start and wr_en pulsed -> outputs stable, no write occurs, and the next search is unaffected.
- Convergence: all off-diagonals set to 1e-6 (0x358637BD) -> converged = 1; set M03 = -2e-5 -> converged = 0 with (0,3) selected.
- Reset at SCAN cycle 3 -> state LOAD, row_ready = 1, loaded = 0, piv_valid = 0. Reload, then start -> correct pivot; row_valid while busy outside LOAD is not accepted.
